// File: rtl/buscar_asignar_seq_pkg.sv
// Shared types and width helpers for the board-matrix key-search engine.
package buscar_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, LAST, DONE} bsq_state_t;

  // Address/code widths never collapse to zero bits, even for 1-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/buscar_asignar_seq_key_match_enc.sv
// Priority encoder: compares one cell against all keys, lowest key index wins.
module key_match_enc
  import buscar_pkg::*;
#(
  parameter int NKEYS = 4,
  parameter int W     = 8,
  localparam int KW   = clog2_min1(NKEYS + 1)
) (
  input  logic [W-1:0]       data,
  input  logic [NKEYS*W-1:0] keys,
  output logic [KW-1:0]      code
);

  // Scanning from the top down lets the lowest matching index overwrite last.
  always_comb begin
    code = '0;
    for (int k = NKEYS - 1; k >= 0; k--) begin
      if (data == keys[k*W +: W]) code = KW'(k + 1);
    end
  end

endmodule

// File: rtl/buscar_asignar_seq.sv
// Sequential key search over a ROWS x COLS board: one cell per clock through a
// synchronous read port, result code written back per cell, hit stats kept.
//
//  state | meaning
//  IDLE  | waiting for start; keys/stop_on_hit latched when start accepted
//  SCAN  | issuing read addresses, writing result of the previous address
//  LAST  | final address already issued; write its result only
//  DONE  | one-cycle done pulse, then back to IDLE
module buscar_asignar_seq
  import buscar_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int W     = 8,
  parameter int NKEYS = 4,
  localparam int RW   = clog2_min1(ROWS),
  localparam int CW   = clog2_min1(COLS),
  localparam int KW   = clog2_min1(NKEYS + 1),
  localparam int MW   = clog2_min1(ROWS * COLS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop_on_hit,
  input  logic [NKEYS*W-1:0] keys,
  output logic [RW-1:0]      rd_row,
  output logic [CW-1:0]      rd_col,
  input  logic [W-1:0]       rd_data,
  output logic               wr_en,
  output logic [RW-1:0]      wr_row,
  output logic [CW-1:0]      wr_col,
  output logic [KW-1:0]      wr_code,
  output logic               busy,
  output logic               done,
  output logic [MW-1:0]      match_cnt,
  output logic               first_valid,
  output logic [RW-1:0]      first_row,
  output logic [CW-1:0]      first_col
);

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [MW-1:0] CNT_MAX  = MW'(ROWS * COLS);

  bsq_state_t         state, state_nxt;
  logic [NKEYS*W-1:0] key_q;
  logic               stop_q;
  logic               pend_valid;
  logic [RW-1:0]      pend_row;
  logic [CW-1:0]      pend_col;
  logic [KW-1:0]      enc_code;
  logic               hit;
  logic               last_addr;
  logic               accept;

  key_match_enc #(
    .NKEYS (NKEYS),
    .W     (W)
  ) u_enc (
    .data (rd_data),
    .keys (key_q),
    .code (enc_code)
  );

  assign accept    = (state == IDLE) && start;
  assign last_addr = (rd_row == ROW_LAST) && (rd_col == COL_LAST);
  assign wr_en     = pend_valid && ((state == SCAN) || (state == LAST));
  assign wr_row    = pend_row;
  assign wr_col    = pend_col;
  assign wr_code   = wr_en ? enc_code : '0;
  assign hit       = wr_en && (enc_code != '0);
  assign busy      = (state == SCAN) || (state == LAST);
  assign done      = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: begin
        if (hit && stop_q)  state_nxt = DONE;
        else if (last_addr) state_nxt = LAST;
      end
      LAST:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q  <= '0;
      stop_q <= 1'b0;
    end else if (accept) begin
      key_q  <= keys;
      stop_q <= stop_on_hit;
    end
  end

  // Address counters walk row-major; they hold on the final cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_row <= '0;
      rd_col <= '0;
    end else if (accept) begin
      rd_row <= '0;
      rd_col <= '0;
    end else if ((state == SCAN) && !last_addr) begin
      if (rd_col == COL_LAST) begin
        rd_col <= '0;
        rd_row <= rd_row + RW'(1);
      end else begin
        rd_col <= rd_col + CW'(1);
      end
    end
  end

  // Pending-address stage lines the write address up with rd_data. A stop
  // jump to DONE leaves the in-flight read unwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_row   <= '0;
      pend_col   <= '0;
    end else begin
      pend_valid <= (state == SCAN) && (state_nxt != DONE);
      if (state == SCAN) begin
        pend_row <= rd_row;
        pend_col <= rd_col;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt   <= '0;
      first_valid <= 1'b0;
      first_row   <= '0;
      first_col   <= '0;
    end else if (accept) begin
      match_cnt   <= '0;
      first_valid <= 1'b0;
      first_row   <= '0;
      first_col   <= '0;
    end else if (hit) begin
      if (match_cnt != CNT_MAX) match_cnt <= match_cnt + MW'(1);
      if (!first_valid) begin
        first_valid <= 1'b1;
        first_row   <= pend_row;
        first_col   <= pend_col;
      end
    end
  end

endmodule

// File: tb/tb_buscar_asignar_seq.sv
// Self-checking bench: table-driven scans on an 8x8x4 instance plus reset and
// 3x5x1 sequences, write stream checked against a scoreboard queue.
module tb_buscar_asignar_seq;

  logic        clk;
  logic        rst;
  logic        start, stop_on_hit;
  logic [31:0] keys;
  logic [2:0]  rd_row, rd_col, wr_row, wr_col, first_row, first_col, wr_code;
  logic [7:0]  rd_data;
  logic        wr_en, busy, done, first_valid;
  logic [6:0]  match_cnt;

  logic        start6, stop6;
  logic [7:0]  keys6, rd_data6;
  logic [1:0]  rd_row6, wr_row6, first_row6;
  logic [2:0]  rd_col6, wr_col6, first_col6;
  logic [0:0]  wr_code6;
  logic        wr_en6, busy6, done6, first_valid6;
  logic [3:0]  match_cnt6;

  logic [7:0] mem  [0:7][0:7];
  logic [7:0] mem6 [0:2][0:4];
  logic [8:0] sb[$];
  logic [5:0] sb6[$];

  int n_checks = 0;
  int n_fail   = 0;

  buscar_asignar_seq dut (
    .clk(clk), .rst(rst), .start(start), .stop_on_hit(stop_on_hit), .keys(keys),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_code(wr_code),
    .busy(busy), .done(done), .match_cnt(match_cnt),
    .first_valid(first_valid), .first_row(first_row), .first_col(first_col)
  );

  buscar_asignar_seq #(.ROWS(3), .COLS(5), .W(8), .NKEYS(1)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .stop_on_hit(stop6), .keys(keys6),
    .rd_row(rd_row6), .rd_col(rd_col6), .rd_data(rd_data6),
    .wr_en(wr_en6), .wr_row(wr_row6), .wr_col(wr_col6), .wr_code(wr_code6),
    .busy(busy6), .done(done6), .match_cnt(match_cnt6),
    .first_valid(first_valid6), .first_row(first_row6), .first_col(first_col6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rd_data  <= mem[rd_row][rd_col];
  always @(posedge clk) rd_data6 <= mem6[rd_row6][rd_col6];

  typedef struct {
    logic [31:0]     keys;
    logic            stop;
    int              ncell;
    logic [2:0][2:0] cr;
    logic [2:0][2:0] cc;
    logic [2:0][7:0] cv;
    int              restart_at;
    logic [31:0]     keys2;
    int              exp_cnt;
    logic            exp_fv;
    int              exp_fr;
    int              exp_fc;
    int              exp_done;
    int              exp_nwr;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(logic [31:0] k, logic s, int n, logic [2:0][2:0] r,
                              logic [2:0][2:0] c, logic [2:0][7:0] v, int ra,
                              logic [31:0] k2, int cnt, logic fv, int fr, int fc,
                              int dc, int nw);
    vec_t t;
    t.keys = k; t.stop = s; t.ncell = n; t.cr = r; t.cc = c; t.cv = v;
    t.restart_at = ra; t.keys2 = k2; t.exp_cnt = cnt; t.exp_fv = fv;
    t.exp_fr = fr; t.exp_fc = fc; t.exp_done = dc; t.exp_nwr = nw;
    return t;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic load_mem(input int i);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mem[r][c] = 8'd0;
    for (int j = 0; j < vecs[i].ncell; j++)
      mem[vecs[i].cr[j]][vecs[i].cc[j]] = vecs[i].cv[j];
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   dc, nwr;
    logic stopped;
    logic [8:0] exp_w;
    v = vecs[i];
    load_mem(i);
    sb.delete();
    stopped = 1'b0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        logic [2:0] code;
        code = 3'd0;
        for (int k = 0; k < 4; k++)
          if (code == 3'd0 && mem[r][c] == v.keys[k*8 +: 8]) code = 3'(k + 1);
        if (!stopped) sb.push_back({3'(r), 3'(c), code});
        if (v.stop && code != 3'd0) stopped = 1'b1;
      end
    end
    dc = -1;
    nwr = 0;
    @(negedge clk);
    keys = v.keys; stop_on_hit = v.stop; start = 1'b1;
    for (int c = 1; c <= 120 && dc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        check($sformatf("v%0d busy_after_start", i), busy, 1);
      end
      if (v.restart_at != 0 && c == v.restart_at) begin
        start = 1'b1;
        keys  = v.keys2;
      end
      if (v.restart_at != 0 && c == v.restart_at + 1) start = 1'b0;
      if (wr_en) begin
        nwr++;
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          check($sformatf("v%0d write#%0d {row,col,code}", i, nwr),
                {wr_row, wr_col, wr_code}, exp_w);
        end
      end
      if (done) dc = c;
    end
    check($sformatf("v%0d done_cycle", i), dc, v.exp_done);
    check($sformatf("v%0d write_count", i), nwr, v.exp_nwr);
    check($sformatf("v%0d unwritten_expected", i), sb.size(), 0);
    check($sformatf("v%0d match_cnt", i), match_cnt, v.exp_cnt);
    check($sformatf("v%0d first_valid", i), first_valid, v.exp_fv);
    check($sformatf("v%0d first_row", i), first_row, v.exp_fr);
    check($sformatf("v%0d first_col", i), first_col, v.exp_fc);
    @(negedge clk);
    check($sformatf("v%0d done_busy_after_pulse", i), {done, busy}, 0);
  endtask

  task automatic run6(input logic s, input int exp_done, input int exp_nwr, input int exp_cnt);
    int dc, nwr;
    logic [5:0] e;
    sb6.delete();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++)
        if (!s || sb6.size() == 0) sb6.push_back({2'(r), 3'(c), 1'b1});
    dc = -1;
    nwr = 0;
    @(negedge clk);
    keys6 = 8'd7; stop6 = s; start6 = 1'b1;
    for (int c = 1; c <= 60 && dc < 0; c++) begin
      @(negedge clk);
      if (c == 1) start6 = 1'b0;
      if (wr_en6) begin
        nwr++;
        if (sb6.size() != 0) begin
          e = sb6.pop_front();
          check($sformatf("t6 stop=%0d write#%0d {row,col,code}", s, nwr),
                {wr_row6, wr_col6, wr_code6}, e);
        end
      end
      if (done6) dc = c;
    end
    check($sformatf("t6 stop=%0d done_cycle", s), dc, exp_done);
    check($sformatf("t6 stop=%0d write_count", s), nwr, exp_nwr);
    check($sformatf("t6 stop=%0d match_cnt", s), match_cnt6, exp_cnt);
    check($sformatf("t6 stop=%0d first", s), {first_valid6, first_row6, first_col6}, 6'b100000);
    @(negedge clk);
  endtask

  initial begin
    int act;
    rst = 1'b1; start = 1'b0; stop_on_hit = 1'b0; keys = '0;
    start6 = 1'b0; stop6 = 1'b0; keys6 = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mem[r][c] = 8'd0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) mem6[r][c] = 8'd7;

    //          keys (k3..k0)              stop n  rows           cols           vals                       ra  keys2                    cnt fv fr fc done nwr
    vecs[0] = mk({8'd10,8'd15,8'd42,8'd27}, 0, 3, {3'd5,3'd2,3'd0}, {3'd7,3'd4,3'd0}, {8'd15,8'd42,8'd27}, 0, 32'd0,                   3, 1, 0, 0, 66, 64);
    vecs[1] = mk({8'd9,8'd9,8'd5,8'd5},     0, 2, {3'd0,3'd7,3'd3}, {3'd0,3'd7,3'd3}, {8'd0,8'd9,8'd5},    0, 32'd0,                   2, 1, 3, 3, 66, 64);
    vecs[2] = mk({8'd10,8'd15,8'd42,8'd27}, 1, 2, {3'd0,3'd5,3'd2}, {3'd0,3'd7,3'd4}, {8'd0,8'd15,8'd42},  0, 32'd0,                   1, 1, 2, 4, 23, 21);
    vecs[3] = mk({8'd10,8'd15,8'd42,8'd27}, 0, 3, {3'd5,3'd2,3'd0}, {3'd7,3'd4,3'd0}, {8'd15,8'd42,8'd27}, 10, {8'd4,8'd3,8'd2,8'd1}, 3, 1, 0, 0, 66, 64);
    vecs[4] = mk({8'd9,8'd8,8'd0,8'd3},     0, 0, '0,               '0,               '0,                  0, 32'd0,                  64, 1, 0, 0, 66, 64);
    vecs[5] = mk({8'd4,8'd3,8'd2,8'd1},     0, 0, '0,               '0,               '0,                  0, 32'd0,                   0, 0, 0, 0, 66, 64);
    vecs[6] = mk({8'd4,8'd3,8'd2,8'd1},     1, 1, {3'd0,3'd0,3'd7}, {3'd0,3'd0,3'd7}, {8'd0,8'd0,8'd4},    0, 32'd0,                   1, 1, 7, 7, 66, 64);

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {wr_en, wr_row, wr_col, wr_code, busy, done, match_cnt,
                            first_valid, first_row, first_col, rd_row, rd_col}, 0);
    check("reset outputs dut6", {wr_en6, wr_row6, wr_col6, wr_code6, busy6, done6,
                                 match_cnt6, first_valid6, first_row6, first_col6,
                                 rd_row6, rd_col6}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Mid-scan reset: outputs clear asynchronously, scan is abandoned.
    load_mem(0);
    @(negedge clk);
    keys = vecs[0].keys; stop_on_hit = 1'b0; start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    check("t4 busy before reset", {busy, first_valid}, 2'b11);
    rst = 1'b1;
    #1;
    check("t4 outputs during reset", {wr_en, wr_row, wr_col, wr_code, busy, done, match_cnt,
                                      first_valid, first_row, first_col, rd_row, rd_col}, 0);
    @(posedge clk);
    #1;
    check("t4 outputs after edge", {wr_en, wr_row, wr_col, wr_code, busy, done, match_cnt,
                                    first_valid, first_row, first_col, rd_row, rd_col}, 0);
    @(negedge clk);
    rst = 1'b0;
    act = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (wr_en || done || busy) act++;
    end
    check("t4 activity after abort", act, 0);
    run_vec(0);

    run6(1'b0, 17, 15, 15);
    run6(1'b1, 3, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got no end of test, expected end before 200000");
    $fatal(1, "timeout");
  end

endmodule
